// File: rtl/mem_bridge.sv
// Clocked req/done front end for the asynchronous data RAM; optional per-access watchdog under MEM_BRIDGE_TIMEOUT_EN.
// Latency: ram_enable rises 2 edges after req is accepted, and done follows ready by 2-3 edges. A bad address completes 1 cycle after req.
// Backpressure: req is sampled only in IDLE; one access is outstanding at a time and busy covers SETUP through DONE.
module mem_bridge #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    CAPACITY       = 1024,
    parameter logic [ADDR_WIDTH-1:0] OFFSET         = ADDR_WIDTH'(32'h00400000),
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_enable,
    output logic                  ram_rw,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_ready
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] STROBE    = 3'd2;
    localparam logic [2:0] WAIT_LOW  = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [ADDR_WIDTH:0] LP_END = {1'b0, OFFSET} + ((ADDR_WIDTH+1)'(CAPACITY) << 2);

    logic [2:0]            r_state;
    logic                  r_rdy_meta;
    logic                  r_rdy_s;
    logic                  r_busy;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_ram_rw;
    logic                  r_ram_enable;
    logic                  w_addr_bad;

    assign w_addr_bad = (addr[1:0] != 2'b00) || (addr < OFFSET) || ({1'b0, addr} >= LP_END);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int LP_CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [LP_CW-1:0] r_to_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rdy_meta   <= 1'b0;
            r_rdy_s      <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_rw     <= 1'b0;
            r_ram_enable <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_rdy_meta <= ram_ready;
            r_rdy_s    <= r_rdy_meta;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        if (w_addr_bad) begin
                            // RAM is never strobed for a bad address, so busy stays low
                            r_state <= DONE;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= SETUP;
                            r_busy      <= 1'b1;
                            r_err       <= 1'b0;
                            r_ram_addr  <= addr;
                            r_ram_wdata <= wdata;
                            r_ram_rw    <= we;
                        end
                    end
                end
                SETUP: r_state <= STROBE;
                STROBE: begin
                    r_state      <= WAIT_LOW;
                    r_ram_enable <= 1'b1;
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    r_to_cnt     <= '0;
`endif
                end
                // ready is still high from the previous access until the RAM reacts to the new edge
                WAIT_LOW: begin
                    if (!r_rdy_s) r_state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (r_rdy_s) begin
                        if (!r_ram_rw) r_rdata <= ram_rdata;
                        r_state      <= DONE;
                        r_ram_enable <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_ram_enable <= 1'b0;
                end
            endcase
`ifdef MEM_BRIDGE_TIMEOUT_EN
            // Placed after the case so a watchdog expiry overrides the normal WAIT transitions
            if (r_state == WAIT_LOW || (r_state == WAIT_HIGH && !r_rdy_s)) begin
                if (r_to_cnt == LP_CW'(TIMEOUT_CYCLES - 1)) begin
                    r_state      <= DONE;
                    r_err        <= 1'b1;
                    r_ram_enable <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
`endif
        end
    end

    assign busy       = r_busy;
    assign done       = (r_state == DONE);
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign ram_rw     = r_ram_rw;
    assign ram_enable = r_ram_enable;

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Clocked front end for the asynchronous, slow data RAM. Accepts single-word read/write requests from the CPU pipeline on a synchronous req/done handshake. Drives the RAM's edge-triggered `enable` / `read_or_write` strobe and waits for the RAM's level `ready`. Returns read data and completion to the CPU. Sits directly upstream of the RAM; the RAM is the only slave.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, byte address width
- `CAPACITY`, 1024, RAM depth in words
- `OFFSET`, 32'h00400000, byte address of RAM word 0
- `TIMEOUT_CYCLES`, 256, clk cycles allowed per RAM access (used only with `MEM_BRIDGE_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  1  CPU request; sampled only in IDLE
- `we`  in  1  1 = write, 0 = read; sampled with `req`
- `addr`  in  ADDR_WIDTH  byte address; sampled with `req`
- `wdata`  in  DATA_WIDTH  write data; sampled with `req`
- `busy`  out  1  high from the cycle after acceptance through DONE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; access failed
- `rdata`  out  DATA_WIDTH  read result; valid from `done`, held until next read completes
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`
- `ram_wdata`  out  DATA_WIDTH  to RAM `write_data`
- `ram_enable`  out  1  to RAM `enable`; RAM acts on its rising edge
- `ram_rw`  out  1  to RAM `read_or_write` (1 = write)
- `ram_rdata`  in  DATA_WIDTH  from RAM `read_data`
- `ram_ready`  in  1  from RAM `ready`; asynchronous to `clk`

## Operation
- `ram_ready` passes through a 2-flop synchronizer (`rdy_s`). Reset value is 0.
- States:
  - IDLE: `req`=1 latches `we`/`addr`/`wdata`.
    - If `addr[1:0]`≠0, `addr`<`OFFSET`, or `addr`≥`OFFSET`+4·`CAPACITY`, go to DONE with `err`=1. The RAM is not touched.
    - Otherwise go to SETUP.
  - SETUP: drives `ram_addr`/`ram_wdata`/`ram_rw` with `ram_enable`=0 for one cycle (address/data setup), then goes to STROBE.
  - STROBE: sets `ram_enable`=1, then goes to WAIT_LOW.
  - WAIT_LOW: stays until `rdy_s`=0, then goes to WAIT_HIGH. This ignores the stale `ready`=1 from the previous access.
  - WAIT_HIGH: stays until `rdy_s`=1. Captures `ram_rdata` into `rdata` on reads; `rdata` is unchanged on writes. Then goes to DONE.
  - DONE: `done`=1 and `ram_enable`=0 for one cycle, then goes to IDLE.
- `ram_addr`, `ram_wdata` and `ram_rw` hold their values from SETUP through DONE.
- `ram_enable` is low in every state except STROBE/WAIT_LOW/WAIT_HIGH. It is therefore always low in IDLE, which guarantees a fresh rising edge per access.
- A `req` outside IDLE is ignored. The CPU holds `req` until it sees `done`; a `req` still high in the cycle after DONE starts a new access.
- Reset mid-access: all state returns to IDLE and `ram_enable` drops immediately. An in-flight RAM write may or may not land; the bridge does not retry.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rdata`=0, `ram_enable`=0, `ram_rw`=0, `ram_addr`=0, `ram_wdata`=0.
- Access latency, from the `req` sample edge:
  - `ram_enable` rises at edge +2.
  - `done` rises on the 2nd–3rd `clk` edge after `ram_ready` rises (synchronizer plus state register).
- Address-error latency: `done`+`err` one cycle after acceptance; `busy` stays 0.
- Throughput: at most one access per (RAM latency + ~6) cycles.

## Configuration
- Macro `MEM_BRIDGE_TIMEOUT_EN`.
- With the macro defined:
  - A cycle counter clears in STROBE and counts in WAIT_LOW/WAIT_HIGH.
  - When the count reaches `TIMEOUT_CYCLES`, the bridge goes to DONE with `err`=1, `ram_enable` drops, and `rdata` is unchanged.
- Without it: no counter. WAIT states wait indefinitely, and `err` comes only from address checks.

## Test plan
- Write 32'hDEADBEEF to 32'h00400010, then read the same address. Required: two `done` pulses, `err`=0, `rdata`=32'hDEADBEEF, `ram_enable` rises exactly twice.
- Read at 32'h00400002 (misaligned), 32'h003FFFFC and 32'h00401000 (out of range). Required: each gives `done`+`err`=1 one cycle after `req`, with no `ram_enable` edge.
- Back-to-back: `req` held high for 3 reads of 32'h00400000/04/08 preloaded with 1, 2, 3. Required: `rdata` 1, 2, 3 on successive `done` pulses, and `ram_enable` low for ≥1 cycle between accesses.
- Assert `rst_n`=0 while in WAIT_HIGH. Required: `ram_enable`=0 and all outputs at reset values immediately; after release, a read completes normally.
- `MEM_BRIDGE_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4 and a RAM model that never raises `ready`. Required: `done`+`err`=1 after 4 waiting cycles, `ram_enable`=0, back to IDLE.
- Hold `ram_ready`=1 from the prior access and change it only at an asynchronous offset from `clk`. Required: the bridge waits for the low phase, and `done` arrives 2–3 edges after the rising edge of `ram_ready`.
